// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the timer display reader.
//   state_t    : conversion FSM states (IDLE, SNAP, SHIFT, LOAD)
//   SEG_*      : active-low seven-segment patterns {g,f,e,d,c,b,a}
//   NUM_DIGITS : number of multiplexed display digits
//   DP_DIGIT   : digit whose decimal point renders the colon
//   bcd_to_seg : BCD digit to segment pattern, blank for codes above 9
// -----------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNAP  = 2'd1,
    SHIFT = 2'd2,
    LOAD  = 2'd3
  } state_t;

  localparam int         NUM_DIGITS  = 4;
  localparam logic [1:0] DP_DIGIT    = 2'd2;
  localparam logic [2:0] SHIFT_STEPS = 3'd6;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/timer_display_bin2bcd6.sv
// -----------------------------------------------------------------------------
// bin2bcd6
// Sequential double-dabble converter: 6-bit binary to two BCD digits.
//   clk       : clock
//   reset_n   : synchronous active-low reset
//   start     : latch bin, clear the accumulator, arm six shift steps
//   bin       : binary value 0..63
//   tens/ones : BCD result, valid while done is high
//   last_step : high during the cycle in which the final shift happens
//   done      : high after the final shift until the next start
// -----------------------------------------------------------------------------
module bin2bcd6
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       last_step,
  output logic       done
);

  logic [5:0] bin_reg, bin_next;
  logic [7:0] bcd_reg, bcd_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       done_reg, done_next;
  logic [7:0] adj;

  always_comb begin
    // add-3 correction on any nibble that would overflow past 9 after the shift
    adj = bcd_reg;
    if (bcd_reg[3:0] >= 4'd5) adj[3:0] = bcd_reg[3:0] + 4'd3;
    if (bcd_reg[7:4] >= 4'd5) adj[7:4] = bcd_reg[7:4] + 4'd3;

    bin_next  = bin_reg;
    bcd_next  = bcd_reg;
    cnt_next  = cnt_reg;
    done_next = done_reg;

    if (start) begin
      bin_next  = bin;
      bcd_next  = '0;
      cnt_next  = SHIFT_STEPS;
      done_next = 1'b0;
    end else if (cnt_reg != 3'd0) begin
      // the binary MSB shifts into the BCD LSB
      {bcd_next, bin_next} = {adj, bin_reg} << 1;
      cnt_next  = cnt_reg - 3'd1;
      done_next = (cnt_reg == 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bin_reg  <= '0;
      bcd_reg  <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      bcd_reg  <= bcd_next;
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

  assign tens      = bcd_reg[7:4];
  assign ones      = bcd_reg[3:0];
  assign last_step = (cnt_reg == 3'd1);
  assign done      = done_reg;

endmodule

// File: rtl/timer_display.sv
// -----------------------------------------------------------------------------
// timer_display
// Snapshots the countdown timer's binary hour/min/sec, converts the selected
// pair to BCD and scans it onto a 4-digit common-anode seven-segment display.
// mode_i=0 shows MM:SS, mode_i=1 shows HH:MM; the colon is digit 2's DP.
//
// Parameters:
//   DIGIT_CYCLES : clk_i cycles each digit stays lit (>= 1)
//   BLINK_HALF   : blink half-period in clk_i cycles (blink build only)
// Ports:
//   clk_i   : 1 kHz system clock
//   reset_i : synchronous active-low reset
//   mode_i  : 0 = MM:SS, 1 = HH:MM
//   hour_i, min_i, sec_i : binary timer values 0..63
//   seg_o   : segments {g,f,e,d,c,b,a}, active-low
//   dp_o    : decimal point, active-low
//   an_o    : one-hot active-low anodes, bit 0 = rightmost digit
//   valid_o : first conversion since reset has completed
//
// Build option: define TIMER_DISPLAY_EXPIRE_BLINK_EN to blink the display
// while the last snapshot was all zero (timer expired).
// -----------------------------------------------------------------------------
module timer_display
  import timer_pkg::*;
#(
  parameter int DIGIT_CYCLES = 2,
  parameter int BLINK_HALF   = 500
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       mode_i,
  input  logic [5:0] hour_i,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [3:0] an_o,
  output logic       valid_o
);

  localparam int REFRESH_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(DIGIT_CYCLES - 1);

  state_t state_reg, state_next;
  logic   conv_start;
  logic   load_now;

  // converter 1 carries the left pair (d3:d2), converter 0 the right pair
  logic [5:0] conv_bin  [2];
  logic [3:0] conv_tens [2];
  logic [3:0] conv_ones [2];
  logic [1:0] conv_last;
  logic [1:0] conv_done;

  logic [3:0]           digit_reg  [NUM_DIGITS];
  logic [3:0]           digit_next [NUM_DIGITS];
  logic                 valid_reg, valid_next;
  logic [REFRESH_W-1:0] refresh_reg, refresh_next;
  logic [1:0]           idx_reg, idx_next;
  logic [6:0]           seg_reg, seg_next;
  logic                 dp_reg, dp_next;
  logic [3:0]           an_reg, an_next;
  logic                 blank;

  assign conv_bin[1] = mode_i ? hour_i : min_i;
  assign conv_bin[0] = mode_i ? min_i  : sec_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_conv
    bin2bcd6 u_conv (
      .clk       (clk_i),
      .reset_n   (reset_i),
      .start     (conv_start),
      .bin       (conv_bin[gi]),
      .tens      (conv_tens[gi]),
      .ones      (conv_ones[gi]),
      .last_step (conv_last[gi]),
      .done      (conv_done[gi])
    );
  end

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    conv_start = 1'b0;
    load_now   = 1'b0;
    unique case (state_reg)
      IDLE:  state_next = SNAP;
      SNAP: begin
        conv_start = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (&conv_last) state_next = LOAD;
      end
      LOAD: begin
        load_now   = &conv_done;
        state_next = SNAP;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- expiry blink ----------------
`ifdef TIMER_DISPLAY_EXPIRE_BLINK_EN
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic               snap_zero_reg;
  logic               expired_reg;
  logic               blink_on_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      snap_zero_reg <= 1'b0;
      expired_reg   <= 1'b0;
      blink_on_reg  <= 1'b0;
      blink_cnt_reg <= '0;
    end else begin
      // expiry looks at all three fields, not just the displayed pair
      if (conv_start) begin
        snap_zero_reg <= (hour_i == 6'd0) && (min_i == 6'd0) && (sec_i == 6'd0);
      end
      if (load_now && !snap_zero_reg) begin
        expired_reg   <= 1'b0;
        blink_on_reg  <= 1'b0;
        blink_cnt_reg <= '0;
      end else begin
        // repeated zero loads must not restart the blink period
        if (load_now) expired_reg <= 1'b1;
        if (expired_reg) begin
          if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= ~blink_on_reg;
          end else begin
            blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
          end
        end
      end
    end
  end

  // phase starts in the off half after expiry
  assign blank = expired_reg && !blink_on_reg;
`else
  assign blank = 1'b0;
`endif

  // ---------------- digit registers and scan ----------------
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) digit_next[i] = digit_reg[i];
    valid_next = valid_reg;
    if (load_now) begin
      digit_next[3] = conv_tens[1];
      digit_next[2] = conv_ones[1];
      digit_next[1] = conv_tens[0];
      digit_next[0] = conv_ones[0];
      valid_next    = 1'b1;
    end

    if (refresh_reg == REFRESH_LAST) begin
      refresh_next = '0;
      idx_next     = idx_reg + 2'd1;
    end else begin
      refresh_next = refresh_reg + REFRESH_W'(1);
      idx_next     = idx_reg;
    end

    // outputs follow the next index and next digit so segments, anodes and
    // a freshly loaded digit all change on the same edge
    seg_next = bcd_to_seg(digit_next[idx_next]);
    dp_next  = blank || (idx_next != DP_DIGIT);
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign an_next[gi] = blank || (idx_next != 2'(gi));
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= '0;
      valid_reg   <= 1'b0;
      refresh_reg <= '0;
      idx_reg     <= '0;
      seg_reg     <= SEG_BLANK;
      dp_reg      <= 1'b1;
      an_reg      <= 4'b1111;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= digit_next[i];
      valid_reg   <= valid_next;
      refresh_reg <= refresh_next;
      idx_reg     <= idx_next;
      seg_reg     <= seg_next;
      dp_reg      <= dp_next;
      an_reg      <= an_next;
    end
  end

  assign seg_o   = seg_reg;
  assign dp_o    = dp_reg;
  assign an_o    = an_reg;
  assign valid_o = valid_reg;

endmodule

// File: tb/tb_timer_display.sv
// -----------------------------------------------------------------------------
// tb_timer_display
// Directed, table-driven bench for timer_display with default parameters
// (DIGIT_CYCLES=2, so one full scan frame is 8 cycles).
// -----------------------------------------------------------------------------
module tb_timer_display;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       mode_i;
  logic [5:0] hour_i, min_i, sec_i;
  logic [6:0] seg_o;
  logic       dp_o;
  logic [3:0] an_o;
  logic       valid_o;

  timer_display dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .mode_i  (mode_i),
    .hour_i  (hour_i),
    .min_i   (min_i),
    .sec_i   (sec_i),
    .seg_o   (seg_o),
    .dp_o    (dp_o),
    .an_o    (an_o),
    .valid_o (valid_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       mode;
    logic [5:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    int         d3, d2, d1, d0;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Watch one full scan frame and compare every digit plus the colon position.
  task automatic check_frame(input string name, input int d3, input int d2,
                             input int d1, input int d0);
    logic [3:0][6:0] segs;
    logic [3:0]      dps;
    logic [3:0]      seen;
    int              exp_d [4];
    int              idx;
    exp_d = '{d0, d1, d2, d3};
    segs  = '1;
    dps   = '1;
    seen  = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      case (an_o)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx >= 0) begin
        segs[idx] = seg_o;
        dps[idx]  = dp_o;
        seen[idx] = 1'b1;
      end
    end
    check({name, " seen"}, 32'(seen), 32'h0000_000F);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s d%0d", name, i), 32'(segs[i]), 32'(exp_seg(exp_d[i])));
    check({name, " dp"}, 32'(dps), 32'b1011);
    $display("frame %s: expect %0d%0d:%0d%0d got seg d3..d0 %h %h %h %h dp %b",
             name, d3, d2, d1, d0, segs[3], segs[2], segs[1], segs[0], dps);
  endtask

  initial begin
    int         n;
    logic       found;
    logic [3:0] prev;
    logic [3:0] exp_an [8];

    vecs[0] = '{1'b0, 6'd0,  6'd5,  6'd0,  0, 5, 0, 0};
    vecs[1] = '{1'b0, 6'd0,  6'd59, 6'd59, 5, 9, 5, 9};
    vecs[2] = '{1'b0, 6'd0,  6'd63, 6'd59, 6, 3, 5, 9};
    vecs[3] = '{1'b1, 6'd12, 6'd34, 6'd0,  1, 2, 3, 4};
    vecs[4] = '{1'b0, 6'd3,  6'd0,  6'd7,  0, 0, 0, 7};
    vecs[5] = '{1'b1, 6'd60, 6'd9,  6'd41, 6, 0, 0, 9};
    exp_an  = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
                4'b1011, 4'b1011, 4'b0111, 4'b0111};

    // reset hold
    reset_i = 1'b0;
    mode_i  = 1'b0;
    hour_i  = 6'd0;
    min_i   = 6'd5;
    sec_i   = 6'd0;
    repeat (3) @(negedge clk);
    check("reset an",    32'(an_o),    32'b1111);
    check("reset seg",   32'(seg_o),   32'h7F);
    check("reset dp",    32'(dp_o),    32'd1);
    check("reset valid", 32'(valid_o), 32'd0);
    $display("reset: an=%b seg=%h dp=%b valid=%b", an_o, seg_o, dp_o, valid_o);

    // first conversion latency
    reset_i = 1'b1;
    n = 0;
    while (valid_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("valid latency", 32'(n), 32'd9);
    $display("first valid after %0d cycles", n);
    check_frame("min5", 0, 5, 0, 0);

    // anode scan order and dwell
    found = 1'b0;
    prev  = an_o;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (an_o == 4'b1110 && prev != 4'b1110) found = 1'b1;
      else prev = an_o;
    end
    check("scan sync", 32'(found), 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("scan an %0d", k), 32'(an_o), 32'(exp_an[k]));
    end
    $display("scan order checked");

    // table-driven vectors
    for (int v = 0; v < 6; v++) begin
      mode_i = vecs[v].mode;
      hour_i = vecs[v].hour;
      min_i  = vecs[v].min;
      sec_i  = vecs[v].sec;
      repeat (17) @(negedge clk);
      check_frame($sformatf("vec%0d", v), vecs[v].d3, vecs[v].d2, vecs[v].d1, vecs[v].d0);
    end

    // mode toggle during SHIFT only shows after the following LOAD
    reset_i = 1'b0;
    mode_i  = 1'b1;
    hour_i  = 6'd12;
    min_i   = 6'd34;
    sec_i   = 6'd56;
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    mode_i = 1'b0;
    repeat (5) @(negedge clk);
    check("toggle valid before load", 32'(valid_o), 32'd0);
    check_frame("pre_toggle", 1, 2, 3, 4);
    check("toggle valid after load", 32'(valid_o), 32'd1);
    check_frame("post_toggle", 3, 4, 5, 6);

    // reset during the 3rd SHIFT cycle (edge 28 after the release above)
    repeat (4) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("abort an",    32'(an_o),    32'b1111);
    check("abort seg",   32'(seg_o),   32'h7F);
    check("abort dp",    32'(dp_o),    32'd1);
    check("abort valid", 32'(valid_o), 32'd0);
    $display("abort: an=%b seg=%h dp=%b valid=%b", an_o, seg_o, dp_o, valid_o);
    reset_i = 1'b1;
    check_frame("after_abort", 0, 0, 0, 0);
    check("abort valid before load", 32'(valid_o), 32'd0);
    @(negedge clk);
    check("abort valid after load", 32'(valid_o), 32'd1);
    check_frame("after_abort_load", 3, 4, 5, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
